// File: rtl/serial_add_ctrl_pkg.sv
// Shared definitions for the bit-serial adder sequencer.
// Holds the controller state encoding, the legal WIDTH limits and a helper
// that sizes the bit counter. Drivers and monitors import the same package so
// they decode the state the same way the controller does.
package serial_add_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int unsigned WIDTH_MIN = 1;
  localparam int unsigned WIDTH_MAX = 32;

  // A one-bit adder still needs a one-bit counter; $clog2(1) would give zero.
  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/serial_add_ctrl_full_adder.sv
// Single-bit full adder cell shared with the ripple-carry datapath.
// Ports:
//   sum       out  a ^ b ^ carry_in
//   carry_out out  majority(a, b, carry_in)
//   a, b      in   addend bits
//   carry_in  in   incoming carry
module full_adder (
  output logic sum,
  output logic carry_out,
  input  logic a,
  input  logic b,
  input  logic carry_in
);

  assign sum       = a ^ b ^ carry_in;
  assign carry_out = (a & b) | (a & carry_in) | (b & carry_in);

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder sequencer.
// Captures two WIDTH-bit operands and a carry-in when start is seen in IDLE,
// then pushes one bit pair per clock (LSB first) through a single full_adder,
// closing the carry loop through carry_q. The sum is collected in a
// right-shifting register. A one-cycle done pulse marks the result valid.
//
// state | meaning
// IDLE  | ready=1, waiting for start; results from last add held
// RUN   | busy=1, one bit processed per edge, WIDTH edges total
// DONE  | done=1 for one cycle, then back to IDLE
//
// Ports:
//   clk      in   rising-edge clock
//   rst      in   synchronous active-high reset, aborts any operation
//   start    in   request; accepted only while ready=1
//   a_in     in   operand A (sampled on accept)
//   b_in     in   operand B (sampled on accept)
//   cin      in   carry-in  (sampled on accept)
//   ready    out  high in IDLE
//   busy     out  high in RUN
//   done     out  one-cycle completion pulse
//   sum_out  out  result, held until the next accept
//   cout     out  final carry, held until the next accept
module serial_add_ctrl
  import serial_add_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum_out,
  output logic             cout
);

  localparam int CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] op_a_q, op_a_d;
  logic [WIDTH-1:0] op_b_q, op_b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic fa_sum;
  logic fa_carry;

  full_adder u_fa (
    .sum       (fa_sum),
    .carry_out (fa_carry),
    .a         (op_a_q[0]),
    .b         (op_b_q[0]),
    .carry_in  (carry_q)
  );

  always_comb begin
    state_d = state_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    cnt_d   = cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          op_a_d  = a_in;
          op_b_d  = b_in;
          carry_d = cin;
          cnt_d   = '0;
          sum_d   = '0;
          cout_d  = 1'b0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        // New sum bit enters at the MSB; after WIDTH shifts bit 0 lands at LSB.
        sum_d   = (sum_q >> 1) | (WIDTH'(fa_sum) << (WIDTH - 1));
        op_a_d  = op_a_q >> 1;
        op_b_d  = op_b_q >> 1;
        carry_d = fa_carry;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          // cout is its own register so it stays cleared while RUN is in flight
          // and only picks up the carry of the last bit.
          cout_d  = fa_carry;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      op_a_q  <= '0;
      op_b_q  <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs decode registered state only, so nothing combinational reaches
  // them from the inputs.
  assign ready   = (state_q == ST_IDLE);
  assign busy    = (state_q == ST_RUN);
  assign done    = (state_q == ST_DONE);
  assign sum_out = sum_q;
  assign cout    = cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
module tb_serial_add_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic       s8 = 1'b0, c8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       rdy8, bsy8, dn8, co8;
  logic [7:0] sum8;

  logic       s4 = 1'b0, c4 = 1'b0;
  logic [3:0] a4 = '0, b4 = '0;
  logic       rdy4, bsy4, dn4, co4;
  logic [3:0] sum4;

  logic       s1 = 1'b0, c1 = 1'b0;
  logic [0:0] a1 = '0, b1 = '0;
  logic       rdy1, bsy1, dn1, co1;
  logic [0:0] sum1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  serial_add_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(s8), .a_in(a8), .b_in(b8), .cin(c8),
    .ready(rdy8), .busy(bsy8), .done(dn8), .sum_out(sum8), .cout(co8));

  serial_add_ctrl #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(s4), .a_in(a4), .b_in(b4), .cin(c4),
    .ready(rdy4), .busy(bsy4), .done(dn4), .sum_out(sum4), .cout(co4));

  serial_add_ctrl #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .start(s1), .a_in(a1), .b_in(b1), .cin(c1),
    .ready(rdy1), .busy(bsy1), .done(dn1), .sum_out(sum1), .cout(co1));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: an addition is the plain integer sum; it completes exactly
  // WIDTH edges after the accept edge and ready returns one edge later.
  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic c,
                      input bit scramble, input string name);
    int cnt;
    logic [8:0] exp;
    exp = 9'(a) + 9'(b) + 9'(c);
    cnt = 0;
    while (rdy8 !== 1'b1 && cnt < 50) begin step(); cnt++; end
    checks++;
    if (rdy8 !== 1'b1) begin
      errors++; $display("FAIL %s_ready_wait: ready=%b required 1", name, rdy8);
    end
    a8 = a; b8 = b; c8 = c; s8 = 1'b1;
    step();
    s8 = 1'b0;
    checks++;
    if (bsy8 !== 1'b1 || rdy8 !== 1'b0 || sum8 !== 8'h00 || co8 !== 1'b0) begin
      errors++;
      $display("FAIL %s_accept: busy=%b ready=%b sum=%h cout=%b required 1 0 00 0",
               name, bsy8, rdy8, sum8, co8);
    end
    cnt = 0;
    while (dn8 !== 1'b1 && cnt < 40) begin
      if (scramble) begin
        a8 = 8'($urandom); b8 = 8'($urandom); c8 = 1'($urandom);
      end
      step(); cnt++;
    end
    checks++;
    if (cnt != 8) begin
      errors++; $display("FAIL %s_latency: edges=%0d required 8", name, cnt);
    end
    checks++;
    if ({co8, sum8} !== exp) begin
      errors++; $display("FAIL %s_result: got %h required %h", name, {co8, sum8}, exp);
    end
    step();
    checks++;
    if (dn8 !== 1'b0 || rdy8 !== 1'b1 || {co8, sum8} !== exp) begin
      errors++;
      $display("FAIL %s_after_done: done=%b ready=%b result=%h required 0 1 %h",
               name, dn8, rdy8, {co8, sum8}, exp);
    end
  endtask

  task automatic run4(input logic [3:0] a, input logic [3:0] b, input logic c);
    int cnt;
    logic [4:0] exp;
    exp = 5'(a) + 5'(b) + 5'(c);
    cnt = 0;
    while (rdy4 !== 1'b1 && cnt < 20) begin step(); cnt++; end
    a4 = a; b4 = b; c4 = c; s4 = 1'b1;
    step();
    s4 = 1'b0;
    cnt = 0;
    while (dn4 !== 1'b1 && cnt < 20) begin step(); cnt++; end
    checks++;
    if (cnt != 4 || {co4, sum4} !== exp) begin
      errors++;
      $display("FAIL w4_add a=%h b=%h cin=%b: edges=%0d result=%h required 4 %h",
               a, b, c, cnt, {co4, sum4}, exp);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    checks++;
    if (rdy8 !== 1 || bsy8 !== 0 || dn8 !== 0 || sum8 !== 0 || co8 !== 0 ||
        rdy4 !== 1 || bsy4 !== 0 || dn4 !== 0 || sum4 !== 0 || co4 !== 0 ||
        rdy1 !== 1 || bsy1 !== 0 || dn1 !== 0 || sum1 !== 0 || co1 !== 0) begin
      errors++;
      $display("FAIL reset_state: w8 r/b/d/s/c=%b%b%b %h %b w4=%b%b%b %h %b w1=%b%b%b %h %b required 100 0 0",
               rdy8, bsy8, dn8, sum8, co8, rdy4, bsy4, dn4, sum4, co4,
               rdy1, bsy1, dn1, sum1, co1);
    end
  endtask

  task automatic test_directed();
    run8(8'hFF, 8'h01, 1'b0, 1'b0, "ff_plus_01");
    run8(8'hA5, 8'h5A, 1'b1, 1'b0, "a5_5a_c1");
    run8(8'hA5, 8'h5A, 1'b0, 1'b0, "a5_5a_c0");
    run8(8'h00, 8'h00, 1'b0, 1'b1, "zero");
    run8(8'hFF, 8'hFF, 1'b1, 1'b1, "all_ones");
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++)
      run8(8'($urandom), 8'($urandom), 1'($urandom), 1'b1, "random");
  endtask

  task automatic test_back_to_back();
    int accepts[$];
    int dones[$];
    int exp_acc[3] = '{0, 10, 20};
    int exp_dn[3]  = '{8, 18, 28};
    bit bad_result;
    bad_result = 1'b0;
    s8 = 1'b1;
    for (int i = 0; i < 30; i++) begin
      if (rdy8 === 1'b1) begin
        a8 = 8'd3; b8 = 8'd4; c8 = 1'b0;
        accepts.push_back(i);
      end else begin
        a8 = 8'($urandom); b8 = 8'($urandom); c8 = 1'($urandom);
      end
      step();
      if (dn8 === 1'b1) begin
        dones.push_back(i);
        if (sum8 !== 8'd7 || co8 !== 1'b0) bad_result = 1'b1;
      end
    end
    s8 = 1'b0;
    checks++;
    if (accepts.size() != 3 || accepts[0] != exp_acc[0] || accepts[1] != exp_acc[1] ||
        accepts[2] != exp_acc[2]) begin
      errors++;
      $display("FAIL b2b_accepts: count=%0d first=%0d required 3 at 0,10,20",
               accepts.size(), (accepts.size() > 0) ? accepts[0] : -1);
    end
    checks++;
    if (dones.size() != 3 || dones[0] != exp_dn[0] || dones[1] != exp_dn[1] ||
        dones[2] != exp_dn[2]) begin
      errors++;
      $display("FAIL b2b_done_pulses: count=%0d required 3 single-cycle at 8,18,28",
               dones.size());
    end
    checks++;
    if (bad_result) begin
      errors++; $display("FAIL b2b_result: a done carried a result other than 3+4=07");
    end
  endtask

  task automatic test_reset_mid_run();
    bit saw_done;
    int cnt;
    cnt = 0;
    while (rdy8 !== 1'b1 && cnt < 20) begin step(); cnt++; end
    a8 = 8'hAA; b8 = 8'h55; c8 = 1'b1; s8 = 1'b1;
    step();
    s8 = 1'b0;
    step(); step(); step();
    rst = 1'b1;
    step();
    checks++;
    if (rdy8 !== 1 || bsy8 !== 0 || dn8 !== 0 || sum8 !== 8'h00 || co8 !== 0) begin
      errors++;
      $display("FAIL rst_mid_run: ready=%b busy=%b done=%b sum=%h cout=%b required 1 0 0 00 0",
               rdy8, bsy8, dn8, sum8, co8);
    end
    s8 = 1'b1; a8 = 8'h01; b8 = 8'h01; c8 = 1'b0;
    step();
    checks++;
    if (bsy8 !== 1'b0 || rdy8 !== 1'b1) begin
      errors++; $display("FAIL rst_with_start: busy=%b ready=%b required 0 1", bsy8, rdy8);
    end
    rst = 1'b0; s8 = 1'b0;
    saw_done = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (dn8 === 1'b1 || bsy8 === 1'b1) saw_done = 1'b1;
    end
    checks++;
    if (saw_done) begin
      errors++; $display("FAIL rst_no_done: activity seen after abort, required none");
    end
    run8(8'h01, 8'h01, 1'b0, 1'b0, "after_rst");
  endtask

  task automatic test_width4_exhaustive();
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        for (int c = 0; c < 2; c++)
          run4(4'(a), 4'(b), 1'(c));
  endtask

  task automatic test_width1();
    int cnt;
    a1 = 1'b1; b1 = 1'b1; c1 = 1'b1; s1 = 1'b1;
    step();
    s1 = 1'b0;
    checks++;
    if (bsy1 !== 1'b1) begin
      errors++; $display("FAIL w1_accept: busy=%b required 1", bsy1);
    end
    cnt = 0;
    while (dn1 !== 1'b1 && cnt < 10) begin step(); cnt++; end
    checks++;
    if (cnt != 1 || sum1 !== 1'b1 || co1 !== 1'b1) begin
      errors++;
      $display("FAIL w1_add: edges=%0d sum=%b cout=%b required 1 1 1", cnt, sum1, co1);
    end
    step();
    checks++;
    if (rdy1 !== 1'b1 || dn1 !== 1'b0) begin
      errors++; $display("FAIL w1_return: ready=%b done=%b required 1 0", rdy1, dn1);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_mid_run();
    test_width4_exhaustive();
    test_width1();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
